procb_sched: RTL

Thread scheduler for the sha256crypt engine's process_bytes path. Scans threads round-robin through a thread_state read/write channel and picks one that is ready for block processing, whose core is ready and whose procb_buf has pending records. Hands the chosen thread to process_bytes with a valid/ack handshake, then holds the grant until process_bytes reports completion, so only one thread owns the procb datapath at a time.

---
 rtl/procb_sched_pkg.sv | 26 ++
 rtl/procb_sched_if.sv | 34 +++
 rtl/procb_sched.sv | 120 ++++++++++++
 3 files changed

// File: rtl/procb_sched_pkg.sv
// procb_sched_pkg: shared types for the process_bytes thread scheduler.
// The thread-state codes mirror the values used across the sha256crypt engine.
package procb_sched_pkg;

    localparam int THREAD_STATE_MSB = 3;

    typedef logic [THREAD_STATE_MSB:0] thread_state_t;

    localparam thread_state_t THREAD_STATE_NONE      = 4'd0;
    localparam thread_state_t THREAD_STATE_PROCB_RDY = 4'd3;
    localparam thread_state_t THREAD_STATE_BUSY      = 4'd7;

    // Index of the most significant bit needed to hold 'value'.
    function automatic int msb(input int value);
        return (value <= 1) ? 0 : $clog2(value + 1) - 1;
    endfunction

    typedef enum logic [2:0] {
        S_SCAN,
        S_CHECK,
        S_LOOKUP,
        S_GRANT,
        S_RUN
    } state_t;

endpackage

// File: rtl/procb_sched_if.sv
// procb_sched_if: thread_state channel, procb_buf lookup and process_bytes
// grant handshake seen by the scheduler (master) and its environment (slave).
interface procb_sched_if
    import procb_sched_pkg::*;
#(
    parameter int N_THREADS_MSB = 2
);

    logic [N_THREADS_MSB:0] ts_rd_num;
    thread_state_t          ts_rd;
    logic [N_THREADS_MSB:0] ts_wr_num;
    logic                   ts_wr_en;
    thread_state_t          ts_wr;
    logic [N_THREADS_MSB:0] lookup_thread_num;
    logic                   lookup_en;
    logic                   lookup_empty;
    logic                   grant_valid;
    logic [N_THREADS_MSB:0] grant_thread;
    logic                   grant_ack;
    logic                   done;

    modport master (
        output ts_rd_num, ts_wr_num, ts_wr_en, ts_wr,
               lookup_thread_num, lookup_en, grant_valid, grant_thread,
        input  ts_rd, lookup_empty, grant_ack, done
    );

    modport slave (
        input  ts_rd_num, ts_wr_num, ts_wr_en, ts_wr,
               lookup_thread_num, lookup_en, grant_valid, grant_thread,
        output ts_rd, lookup_empty, grant_ack, done
    );

endinterface

// File: rtl/procb_sched.sv
// procb_sched: round-robin picker of a thread that is PROCB_RDY, whose core is
// ready and whose procb_buf has records; grants it to process_bytes and holds
// ownership of the procb datapath until process_bytes reports done.
module procb_sched
    import procb_sched_pkg::*;
#(
    parameter int N_CORES = 3
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 en,
    input  logic [N_CORES-1:0]   core_ready,
    procb_sched_if.master        bus,
    output logic                 idle,
    output logic                 err
);

    localparam int N_THREADS     = 2 * N_CORES;
    localparam int N_THREADS_MSB = msb(N_THREADS - 1);

    typedef logic [N_THREADS_MSB:0] thread_t;

    localparam thread_t LAST_THREAD = thread_t'(N_THREADS - 1);

    state_t                 state;
    state_t                 state_nxt;
    thread_t                ptr;
    logic [N_THREADS_MSB-1:0] core_idx;
    logic                   eligible;
    logic                   advance;
    logic                   proto_err;

    // Thread count is not a power of two, so wrap explicitly.
    function automatic thread_t next_thread(input thread_t t);
        return (t == LAST_THREAD) ? '0 : thread_t'(t + 1'b1);
    endfunction

    assign core_idx = ptr[N_THREADS_MSB:1];
    assign eligible = (bus.ts_rd == THREAD_STATE_PROCB_RDY) && core_ready[core_idx];
    assign advance  = ((state == S_CHECK)  && !eligible)
                   || ((state == S_LOOKUP) && bus.lookup_empty)
                   || ((state == S_RUN)    && bus.done);
    assign bus.ts_wr = THREAD_STATE_BUSY;

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= S_SCAN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: only leaving S_SCAN is gated by en.
    always_comb begin
        state_nxt = state;
        case (state)
            S_SCAN:   if (en) state_nxt = S_CHECK;
            S_CHECK:  state_nxt = eligible ? S_LOOKUP : S_SCAN;
            S_LOOKUP: state_nxt = bus.lookup_empty ? S_SCAN : S_GRANT;
            S_GRANT:  if (bus.grant_ack) state_nxt = S_RUN;
            S_RUN:    if (bus.done) state_nxt = S_SCAN;
            default:  state_nxt = S_SCAN;
        endcase
    end

    // Combinational outputs and protocol violation detection.
    always_comb begin
        idle      = (state == S_SCAN);
        proto_err = (bus.grant_ack && (state != S_GRANT))
                 || (bus.done && (state != S_RUN))
                 || (bus.done && bus.grant_ack);
    end

    // Scan pointer, registered addresses, strobes and the grant itself.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ptr                   <= '0;
            bus.ts_rd_num         <= '0;
            bus.ts_wr_en          <= 1'b0;
            bus.ts_wr_num         <= '0;
            bus.lookup_en         <= 1'b0;
            bus.lookup_thread_num <= '0;
            bus.grant_valid       <= 1'b0;
            bus.grant_thread      <= '0;
        end else begin
            bus.ts_wr_en  <= 1'b0;
            bus.lookup_en <= 1'b0;
            if (advance) begin
                ptr <= next_thread(ptr);
            end
            if ((state == S_SCAN) && en) begin
                bus.ts_rd_num <= ptr;
            end
            if ((state == S_CHECK) && eligible) begin
                bus.lookup_en         <= 1'b1;
                bus.lookup_thread_num <= ptr;
            end
            if ((state == S_LOOKUP) && !bus.lookup_empty) begin
                bus.ts_wr_en     <= 1'b1;
                bus.ts_wr_num    <= ptr;
                bus.grant_thread <= ptr;
                bus.grant_valid  <= 1'b1;
            end
            if ((state == S_GRANT) && bus.grant_ack) begin
                bus.grant_valid <= 1'b0;
            end
        end
    end

    // Sticky protocol error flag, cleared only by reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            err <= 1'b0;
        end else if (proto_err) begin
            err <= 1'b1;
        end
    end

endmodule
